// File: rtl/str_pkg.sv
// Shared state type and tkeep helpers for the stream byte packer.
// Keep masks are zero-extended to KEEP_MAX lanes before being passed to the helpers.
package str_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } str_state_e;

    localparam int KEEP_MAX = 64;

    function automatic int str_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int keep_count(input logic [KEEP_MAX-1:0] keep, input int n);
        int c;
        c = 0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            if (i < n && keep[i]) c++;
        end
        return c;
    endfunction

    // Index of the lowest clear lane, or n when every lane is set.
    function automatic int keep_prefix(input logic [KEEP_MAX-1:0] keep, input int n);
        int  p;
        bit  found;
        p     = n;
        found = 1'b0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            if (!found && i < n && !keep[i]) begin
                p     = i;
                found = 1'b1;
            end
        end
        return p;
    endfunction

    function automatic logic keep_contig(input logic [KEEP_MAX-1:0] keep, input int n);
        return keep_count(keep, n) == keep_prefix(keep, n);
    endfunction

endpackage

// File: rtl/str_keep_compact.sv
// Combinational lane gather: kept lanes move down to the lowest free positions,
// preserving ascending order; lanes above the kept count are zero.
module str_keep_compact #(
    parameter int DATA_WIDTH = 64,
    parameter int WORD_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0]            data_i,
    input  logic [DATA_WIDTH/WORD_WIDTH-1:0] keep_i,
    output logic [DATA_WIDTH-1:0]            data_o
);

    localparam int N = DATA_WIDTH / WORD_WIDTH;

    always_comb begin
        int idx;
        data_o = '0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            if (keep_i[i]) begin
                data_o[idx*WORD_WIDTH +: WORD_WIDTH] = data_i[i*WORD_WIDTH +: WORD_WIDTH];
                idx++;
            end
        end
    end

endmodule

// File: rtl/str_byte_packer.sv
// AXI-stream byte packer: turns beats with partial tkeep into dense beats, only the last one short.
// Define STR_PACK_SPARSE_EN to gather arbitrary tkeep patterns; otherwise only the contiguous prefix is taken.
module str_byte_packer
    import str_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int WORD_WIDTH = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
    input  logic [DATA_WIDTH/WORD_WIDTH-1:0] s_axis_tkeep,
    input  logic                             s_axis_tlast,
    input  logic                             s_axis_tvld,
    output logic                             s_axis_trdy,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [DATA_WIDTH/WORD_WIDTH-1:0] m_axis_tkeep,
    output logic                             m_axis_tlast,
    output logic                             m_axis_tvld,
    input  logic                             m_axis_trdy,
    output logic                             o_keep_err
);

    localparam int            N   = DATA_WIDTH / WORD_WIDTH;
    localparam int            CW  = str_clog2(2 * N);
    localparam logic [CW-1:0] N_C = CW'(N);

    str_state_e              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2*DATA_WIDTH-1:0] buf_q, buf_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [N-1:0]            out_keep_q, out_keep_d;
    logic                    out_last_q, out_last_d;
    logic                    out_vld_q, out_vld_d;
    logic                    keep_err_q, keep_err_d;

    logic                    out_rdy;
    logic                    in_rdy;
    logic                    accept;
    logic [CW-1:0]           in_cnt;
    logic [CW-1:0]           base_cnt;
    logic [DATA_WIDTH-1:0]   in_lanes;
    logic [DATA_WIDTH-1:0]   in_masked;
    logic [2*DATA_WIDTH-1:0] base_buf;
    logic [N-1:0]            tail_keep;

`ifdef STR_PACK_SPARSE_EN
    str_keep_compact #(
        .DATA_WIDTH(DATA_WIDTH),
        .WORD_WIDTH(WORD_WIDTH)
    ) u_compact (
        .data_i(s_axis_tdata),
        .keep_i(s_axis_tkeep),
        .data_o(in_lanes)
    );
    assign in_cnt     = CW'(keep_count(KEEP_MAX'(s_axis_tkeep), N));
    assign keep_err_d = 1'b0;
`else
    assign in_lanes   = s_axis_tdata;
    assign in_cnt     = CW'(keep_prefix(KEEP_MAX'(s_axis_tkeep), N));
    assign keep_err_d = accept & ~keep_contig(KEEP_MAX'(s_axis_tkeep), N);
`endif

    assign out_rdy     = m_axis_trdy | ~out_vld_q;
    assign in_rdy      = (state_q == FILL) && ((cnt_q < N_C) || out_rdy);
    assign accept      = in_rdy & s_axis_tvld & ~i_rst;
    assign s_axis_trdy = in_rdy & ~i_rst;

    // Lanes at or above cnt are kept zero so appends can simply OR into the buffer.
    always_comb begin
        in_masked = '0;
        tail_keep = '0;
        for (int i = 0; i < N; i++) begin
            if (CW'(i) < in_cnt)
                in_masked[i*WORD_WIDTH +: WORD_WIDTH] = in_lanes[i*WORD_WIDTH +: WORD_WIDTH];
            tail_keep[i] = (CW'(i) < cnt_q);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        out_data_d = out_data_q;
        out_keep_d = out_keep_q;
        out_last_d = out_last_q;
        out_vld_d  = out_vld_q & ~m_axis_trdy;
        base_buf   = buf_q;
        base_cnt   = cnt_q;
        case (state_q)
            FILL: begin
                if (cnt_q >= N_C && out_rdy) begin
                    out_data_d = buf_q[DATA_WIDTH-1:0];
                    out_keep_d = '1;
                    out_last_d = 1'b0;
                    out_vld_d  = 1'b1;
                    base_buf   = buf_q >> DATA_WIDTH;
                    base_cnt   = cnt_q - N_C;
                end
                buf_d = base_buf;
                cnt_d = base_cnt;
                if (accept) begin
                    buf_d = base_buf | ({{DATA_WIDTH{1'b0}}, in_masked} << (int'(base_cnt) * WORD_WIDTH));
                    cnt_d = base_cnt + in_cnt;
                    if (s_axis_tlast) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (out_rdy) begin
                    out_data_d = buf_q[DATA_WIDTH-1:0];
                    out_vld_d  = 1'b1;
                    if (cnt_q > N_C) begin
                        out_keep_d = '1;
                        out_last_d = 1'b0;
                        buf_d      = buf_q >> DATA_WIDTH;
                        cnt_d      = cnt_q - N_C;
                    end else begin
                        out_keep_d = tail_keep;
                        out_last_d = 1'b1;
                        buf_d      = '0;
                        cnt_d      = '0;
                        state_d    = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            buf_q      <= '0;
            out_data_q <= '0;
            out_keep_q <= '0;
            out_last_q <= 1'b0;
            out_vld_q  <= 1'b0;
            keep_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            out_data_q <= out_data_d;
            out_keep_q <= out_keep_d;
            out_last_q <= out_last_d;
            out_vld_q  <= out_vld_d;
            keep_err_q <= keep_err_d;
        end
    end

    assign m_axis_tdata = out_data_q;
    assign m_axis_tkeep = out_keep_q;
    assign m_axis_tlast = out_last_q;
    assign m_axis_tvld  = out_vld_q;
    assign o_keep_err   = keep_err_q;

endmodule
